// File: rtl/riscv_pkg.sv
// Shared types and sizes for the issue-side scoreboard.
package riscv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/riscv_sb_regfile.sv
// Pending-bit vector for registers owned by in-flight long-latency ops.
// eff_pending is the current view with this cycle's completion already removed.
module riscv_sb_regfile
  import riscv_pkg::reg_addr_t;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_en,
  input  reg_addr_t           clr_addr,
  input  logic                set_en,
  input  reg_addr_t           set_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic [NUM_REGS-1:0] eff_pending
);

  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] pend_nxt;

  // Set wins over clear on the same index; x0 is never tracked.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
    if (set_en) set_mask[set_addr] = 1'b1;
    eff_pending = pending & ~clr_mask;
    pend_nxt    = eff_pending | set_mask;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pend_nxt;
  end

endmodule

// File: rtl/riscv_scoreboard_interlock.sv
// ID-stage interlock: stalls issue on RAW/WAW hazards against in-flight long-latency
// results and on a busy divider; also keeps stall statistics and a sticky hang flag.
module riscv_scoreboard_interlock
  import riscv_pkg::reg_addr_t;
#(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  reg_addr_t           id_rs1_addr,
  input  logic                id_rs1_used,
  input  reg_addr_t           id_rs2_addr,
  input  logic                id_rs2_used,
  input  reg_addr_t           id_rd_addr,
  input  logic                id_rd_wr,
  input  logic                id_long_lat,
  input  logic                id_is_div,
  input  logic                flush,
  input  logic                cmpl_valid,
  input  reg_addr_t           cmpl_rd_addr,
  input  logic                div_done,
  output logic                stall,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                div_busy,
  output logic [CNT_W-1:0]    stall_count,
  output logic                hang_err
);

  localparam int unsigned RUN_W = $clog2(STALL_TIMEOUT + 1);

  logic [NUM_REGS-1:0] eff_pending;
  logic [RUN_W-1:0]    run_cnt;
  logic                raw_haz;
  logic                waw_haz;
  logic                str_haz;
  logic                set_en;

  riscv_sb_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .clr_en      (cmpl_valid),
    .clr_addr    (cmpl_rd_addr),
    .set_en      (set_en),
    .set_addr    (id_rd_addr),
    .pending     (pending_mask),
    .eff_pending (eff_pending)
  );

  // Hazard detection against the completion-adjusted pending view.
  always_comb begin
    raw_haz    = (id_rs1_used && (id_rs1_addr != '0) && eff_pending[id_rs1_addr]) ||
                 (id_rs2_used && (id_rs2_addr != '0) && eff_pending[id_rs2_addr]);
    waw_haz    = id_rd_wr && (id_rd_addr != '0) && eff_pending[id_rd_addr];
    str_haz    = id_is_div && div_busy && !div_done;
    stall      = !rst && id_valid && !flush && (raw_haz || waw_haz || str_haz);
    issue_fire = !rst && id_valid && !flush && !stall;
    set_en     = issue_fire && id_long_lat && id_rd_wr && (id_rd_addr != '0);
  end

  // A new div issuing in the same cycle the old one finishes keeps the divider busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy <= 1'b0;
    end else if (issue_fire && id_is_div) begin
      div_busy <= 1'b1;
    end else if (div_done) begin
      div_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      run_cnt     <= '0;
      hang_err    <= 1'b0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (!stall) begin
        run_cnt <= '0;
      end else if (run_cnt != RUN_W'(STALL_TIMEOUT)) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
      if (stall && (run_cnt == RUN_W'(STALL_TIMEOUT - 1))) hang_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_scoreboard_interlock.sv
// Self-checking bench: directed vector table, hand sequences for multi-cycle cases,
// and randomized traffic against a behavioural scoreboard model.
module tb_riscv_scoreboard_interlock;

  localparam int unsigned TO = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wr, id_long_lat, id_is_div;
  logic        flush, cmpl_valid, div_done;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, cmpl_rd_addr;
  logic        stall, issue_fire, div_busy, hang_err;
  logic [31:0] pending_mask;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_scoreboard_interlock dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs2_used  (id_rs2_used),
    .id_rd_addr   (id_rd_addr),
    .id_rd_wr     (id_rd_wr),
    .id_long_lat  (id_long_lat),
    .id_is_div    (id_is_div),
    .flush        (flush),
    .cmpl_valid   (cmpl_valid),
    .cmpl_rd_addr (cmpl_rd_addr),
    .div_done     (div_done),
    .stall        (stall),
    .issue_fire   (issue_fire),
    .pending_mask (pending_mask),
    .div_busy     (div_busy),
    .stall_count  (stall_count),
    .hang_err     (hang_err)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ll;
    logic       dv;
    logic       fl;
    logic       cv;
    logic [4:0] crd;
    logic       dd;
  } in_t;

  typedef struct {
    in_t         i;
    logic        e_stall;
    logic        e_issue;
    logic [31:0] e_mask;
  } vec_t;

  // Behavioural model state: set of registers awaiting a long-latency result.
  bit          m_pend [32];
  bit          m_busy;
  longint      m_cnt;
  int          m_run;
  bit          m_hang;

  function automatic in_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                             logic [4:0] rd, logic wr, logic ll, logic dv, logic fl,
                             logic cv, logic [4:0] crd, logic dd);
    in_t r;
    r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.rd = rd; r.wr = wr;
    r.ll = ll; r.dv = dv; r.fl = fl; r.cv = cv; r.crd = crd; r.dd = dd;
    return r;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int k = 1; k < 32; k++) m[k] = m_pend[k];
    return m;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 32; k++) m_pend[k] = 1'b0;
    m_busy = 1'b0; m_cnt = 0; m_run = 0; m_hang = 1'b0;
  endfunction

  function automatic bit waits_on(logic [4:0] r, in_t i);
    if (r == 5'd0) return 1'b0;
    if (i.cv && i.crd == r) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic void m_eval(in_t i, output bit st, output bit is);
    bit haz;
    haz = (i.u1 && waits_on(i.rs1, i)) || (i.u2 && waits_on(i.rs2, i)) ||
          (i.wr && waits_on(i.rd, i)) || (i.dv && m_busy && !i.dd);
    st = i.v && !i.fl && haz;
    is = i.v && !i.fl && !haz;
  endfunction

  function automatic void m_update(in_t i, bit st, bit is);
    if (i.cv) m_pend[i.crd] = 1'b0;
    if (is && i.ll && i.wr && i.rd != 5'd0) m_pend[i.rd] = 1'b1;
    if (is && i.dv) m_busy = 1'b1;
    else if (i.dd)  m_busy = 1'b0;
    if (st) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_run++;
      if (m_run >= TO) m_hang = 1'b1;
    end else begin
      m_run = 0;
    end
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(in_t i);
    id_valid = i.v; id_rs1_addr = i.rs1; id_rs1_used = i.u1; id_rs2_addr = i.rs2;
    id_rs2_used = i.u2; id_rd_addr = i.rd; id_rd_wr = i.wr; id_long_lat = i.ll;
    id_is_div = i.dv; flush = i.fl; cmpl_valid = i.cv; cmpl_rd_addr = i.crd; div_done = i.dd;
  endtask

  // One clock: called just after a negedge; checks combinational and registered outputs.
  task automatic step(input in_t i, output logic a_st, output logic a_is);
    bit st, is;
    apply(i);
    #1;
    m_eval(i, st, is);
    a_st = stall;
    a_is = issue_fire;
    chk("stall", 64'(stall), 64'(st));
    chk("issue_fire", 64'(issue_fire), 64'(is));
    @(posedge clk);
    m_update(i, st, is);
    @(negedge clk);
    chk("pending_mask", 64'(pending_mask), 64'(m_mask()));
    chk("div_busy", 64'(div_busy), 64'(m_busy));
    chk("stall_count", 64'(stall_count), 64'(m_cnt));
    chk("hang_err", 64'(hang_err), 64'(m_hang));
  endtask

  task automatic do_reset();
    apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs [10];
  in_t  idle;
  logic a_st, a_is;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
    //                v rs1 u1 rs2 u2 rd wr ll dv fl cv crd dd    stall issue mask-after
    vecs[0] = '{mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h0000_0020};
    vecs[1] = '{mk(1, 5, 1, 2, 1, 6, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 32'h0000_0020};
    vecs[2] = '{mk(1, 5, 1, 2, 1, 6, 1, 0, 0, 0, 1, 5, 0), 1'b0, 1'b1, 32'h0000_0000};
    vecs[3] = '{mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h0000_0000};
    vecs[4] = '{mk(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h0000_0000};
    vecs[5] = '{mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h0000_0080};
    vecs[6] = '{mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1, 7, 0), 1'b0, 1'b1, 32'h0000_0080};
    vecs[7] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0), 1'b0, 1'b0, 32'h0000_0000};
    vecs[8] = '{mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 1, 0, 0, 0), 1'b0, 1'b0, 32'h0000_0000};
    vecs[9] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0), 1'b0, 1'b0, 32'h0000_0000};

    rst = 1'b1;
    apply(idle);
    @(negedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_count", 64'(stall_count), 64'd0);
    do_reset();

    // Directed table: load-use, x0 handling, same-cycle completion vs reissue, flush.
    for (int k = 0; k < 10; k++) begin
      step(vecs[k].i, a_st, a_is);
      chk($sformatf("tbl%0d_stall", k), 64'(a_st), 64'(vecs[k].e_stall));
      chk($sformatf("tbl%0d_issue", k), 64'(a_is), 64'(vecs[k].e_issue));
      chk($sformatf("tbl%0d_mask", k), 64'(pending_mask), 64'(vecs[k].e_mask));
    end
    chk("tbl_stall_count", 64'(stall_count), 64'd1);

    // Divider structural hazard and done/issue overlap.
    do_reset();
    step(mk(1,0,0,0,0,10,1,1,1,0,0,0,0), a_st, a_is);
    chk("div1_busy", 64'(div_busy), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step(mk(1,0,0,0,0,11,1,1,1,0,0,0,0), a_st, a_is);
      chk("div2_stall", 64'(a_st), 64'd1);
    end
    step(mk(1,0,0,0,0,11,1,1,1,0,0,0,1), a_st, a_is);
    chk("div2_issue", 64'(a_is), 64'd1);
    chk("div_busy_overlap", 64'(div_busy), 64'd1);
    step(mk(0,0,0,0,0,0,0,0,0,0,0,0,1), a_st, a_is);
    chk("div_busy_clear", 64'(div_busy), 64'd0);

    // Hang detection: hold a RAW stall for exactly the timeout.
    do_reset();
    step(mk(1,0,0,0,0,4,1,1,0,0,0,0,0), a_st, a_is);
    for (int k = 0; k < int'(TO); k++) begin
      step(mk(1,4,1,0,0,6,1,0,0,0,0,0,0), a_st, a_is);
      if (k == int'(TO) - 2) chk("hang_before_timeout", 64'(hang_err), 64'd0);
    end
    chk("hang_at_timeout", 64'(hang_err), 64'd1);
    chk("hang_stall_count", 64'(stall_count), 64'(TO));
    step(mk(1,4,1,0,0,6,1,0,0,0,1,4,0), a_st, a_is);
    chk("hang_release_issue", 64'(a_is), 64'd1);
    step(idle, a_st, a_is);
    chk("hang_sticky", 64'(hang_err), 64'd1);

    // Asynchronous reset mid-cycle with pending bits 5 and 8 set.
    do_reset();
    step(mk(1,0,0,0,0,5,1,1,0,0,0,0,0), a_st, a_is);
    step(mk(1,0,0,0,0,8,1,1,1,0,0,0,0), a_st, a_is);
    chk("pre_rst_mask", 64'(pending_mask), 64'h120);
    apply(mk(1,5,1,0,0,6,1,0,0,0,0,0,0));
    #1;
    chk("pre_rst_stall", 64'(stall), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_mask", 64'(pending_mask), 64'd0);
    chk("async_rst_stall", 64'(stall), 64'd0);
    chk("async_rst_busy", 64'(div_busy), 64'd0);
    chk("async_rst_cnt", 64'(stall_count), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    step(mk(0,0,0,0,0,0,0,0,0,0,1,5,1), a_st, a_is);
    chk("post_rst_mask", 64'(pending_mask), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      in_t r;
      r.v   = ($urandom_range(0, 3) != 0);
      r.rs1 = 5'($urandom_range(0, 7));
      r.u1  = 1'($urandom_range(0, 1));
      r.rs2 = 5'($urandom_range(0, 7));
      r.u2  = 1'($urandom_range(0, 1));
      r.rd  = 5'($urandom_range(0, 7));
      r.wr  = ($urandom_range(0, 4) != 0);
      r.ll  = ($urandom_range(0, 9) < 4);
      r.dv  = ($urandom_range(0, 9) < 2);
      r.fl  = ($urandom_range(0, 9) == 0);
      r.cv  = ($urandom_range(0, 9) < 3);
      r.crd = 5'($urandom_range(0, 7));
      r.dd  = ($urandom_range(0, 9) < 2);
      step(r, a_st, a_is);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
